// File: rtl/dbus_bridge_2023211063.sv
// Data-memory bridge: posts stores through a small write FIFO and turns loads
// into split request/response bus reads, stalling the core via hold_flag_o.
module dbus_bridge_2023211063 #(
  parameter int WB_DEPTH = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_ack_o,
  output logic              hold_flag_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_RREQ  = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [ADDR_W-1:0] wb_addr_q [WB_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic is_idle, is_drain, is_rreq, is_rwait, is_done;
  logic wb_empty, wb_full;
  logic load_req, store_req;
  logic push, pop, drain;

  assign is_idle  = (state_q == S_IDLE);
  assign is_drain = (state_q == S_DRAIN);
  assign is_rreq  = (state_q == S_RREQ);
  assign is_rwait = (state_q == S_RWAIT);
  assign is_done  = (state_q == S_DONE);

  assign wb_empty  = (count_q == '0);
  assign wb_full   = (count_q == CNT_W'(WB_DEPTH));
  assign load_req  = core_req_i & ~core_we_i;
  assign store_req = core_req_i &  core_we_i;

  // Full test uses the registered count: a same-cycle pop does not free a slot.
  assign push  = store_req & is_idle & ~wb_full;
  assign drain = ~wb_empty & (is_idle | is_drain);
  assign pop   = drain & bus_gnt_i;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d = state_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          raddr_d = core_addr_i;
          state_d = wb_empty ? S_RREQ : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (count_d == '0) state_d = S_RREQ;
      end
      S_RREQ: begin
        if (bus_gnt_i) begin
          if (bus_rvalid_i) begin
            rdata_d = bus_rdata_i;
            state_d = S_DONE;
          end else begin
            state_d = S_RWAIT;
          end
        end
      end
      S_RWAIT: begin
        if (bus_rvalid_i) begin
          rdata_d = bus_rdata_i;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: the FIFO storage is not reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[wr_ptr_q] <= core_addr_i;
      wb_data_q[wr_ptr_q] <= core_wdata_i;
    end
  end

  assign bus_req_o   = drain | is_rreq;
  assign bus_we_o    = drain;
  assign bus_addr_o  = drain ? wb_addr_q[rd_ptr_q] : (is_rreq ? raddr_q : '0);
  assign bus_wdata_o = drain ? wb_data_q[rd_ptr_q] : '0;

  assign core_ack_o   = push | is_done;
  assign core_rdata_o = rdata_q;
  assign hold_flag_o  = (is_idle & load_req) | (is_idle & store_req & wb_full)
                      | is_drain | is_rreq | is_rwait;

endmodule

// File: tb/tb_dbus_bridge_2023211063.sv
// Directed bench for dbus_bridge_2023211063: a monitor compares every granted bus
// transfer against a scoreboard queue filled as the core-side stimulus is driven.
module tb_dbus_bridge_2023211063;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_i, core_we_i;
  logic [31:0] core_addr_i, core_wdata_i, core_rdata_o;
  logic        core_ack_o, hold_flag_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_op_t;

  bus_op_t sb[$];
  int      checks = 0;
  int      errors = 0;

  dbus_bridge_2023211063 #(.WB_DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_addr_i  (core_addr_i),
    .core_wdata_i (core_wdata_i),
    .core_rdata_o (core_rdata_o),
    .core_ack_o   (core_ack_o),
    .hold_flag_o  (hold_flag_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core(input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata);
    core_req_i   = req;
    core_we_i    = we;
    core_addr_i  = addr;
    core_wdata_i = wdata;
  endtask

  task automatic expect_op(input logic we, input logic [31:0] addr, input logic [31:0] data);
    bus_op_t op;
    op.we   = we;
    op.addr = addr;
    op.data = data;
    sb.push_back(op);
  endtask

  // Every accepted bus transfer must match the oldest expected operation.
  always @(negedge clk) begin
    if (!rst && bus_req_o && bus_gnt_i) begin
      if (sb.size() == 0) begin
        check("bus_unexpected", 32'(bus_req_o), 32'd0);
      end else begin
        bus_op_t op;
        op = sb.pop_front();
        check("bus_we", 32'(bus_we_o), 32'(op.we));
        check("bus_addr", bus_addr_o, op.addr);
        if (op.we) check("bus_wdata", bus_wdata_o, op.data);
      end
    end
  end

  initial begin
    logic found;
    rst = 1'b1;
    core(1'b0, 1'b0, 32'h0, 32'h0);
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack",   32'(core_ack_o),  32'd0);
    check("rst_hold",  32'(hold_flag_o), 32'd0);
    check("rst_req",   32'(bus_req_o),   32'd0);
    check("rst_addr",  bus_addr_o,       32'h0);
    check("rst_rdata", core_rdata_o,     32'h0);

    // Single posted store, drained the following cycle.
    step(); core(1'b1, 1'b1, 32'h1000, 32'hDEADBEEF); bus_gnt_i = 1'b1;
    @(negedge clk);
    check("st1_ack",  32'(core_ack_o),  32'd1);
    check("st1_hold", 32'(hold_flag_o), 32'd0);
    check("st1_req",  32'(bus_req_o),   32'd0);
    expect_op(1'b1, 32'h1000, 32'hDEADBEEF);
    step(); core(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("st1_drain_req", 32'(bus_req_o), 32'd1);
    step(); bus_gnt_i = 1'b0;
    @(negedge clk);
    check("st1_empty", 32'(bus_req_o), 32'd0);

    // Fill the FIFO, stall a third store, free one slot for a cycle.
    step(); core(1'b1, 1'b1, 32'h10, 32'h1111);
    @(negedge clk); check("full_st0_ack", 32'(core_ack_o), 32'd1);
    expect_op(1'b1, 32'h10, 32'h1111);
    step(); core(1'b1, 1'b1, 32'h14, 32'h2222);
    @(negedge clk); check("full_st1_ack", 32'(core_ack_o), 32'd1);
    expect_op(1'b1, 32'h14, 32'h2222);
    step(); core(1'b1, 1'b1, 32'h18, 32'h3333);
    @(negedge clk);
    check("full_st2_ack",  32'(core_ack_o),  32'd0);
    check("full_st2_hold", 32'(hold_flag_o), 32'd1);
    step(); bus_gnt_i = 1'b1;
    @(negedge clk);
    check("full_pop_ack", 32'(core_ack_o), 32'd0);
    step(); bus_gnt_i = 1'b0;
    @(negedge clk);
    check("full_retry_ack",  32'(core_ack_o),  32'd1);
    check("full_retry_hold", 32'(hold_flag_o), 32'd0);
    expect_op(1'b1, 32'h18, 32'h3333);
    step(); core(1'b0, 1'b0, 32'h0, 32'h0); bus_gnt_i = 1'b1;
    step();
    step(); bus_gnt_i = 1'b0;
    @(negedge clk);
    check("full_drained", 32'(bus_req_o), 32'd0);

    // Load behind two buffered stores must follow them on the bus.
    step(); core(1'b1, 1'b1, 32'h10, 32'hA0A0A0A0);
    expect_op(1'b1, 32'h10, 32'hA0A0A0A0);
    step(); core(1'b1, 1'b1, 32'h14, 32'hB0B0B0B0);
    expect_op(1'b1, 32'h14, 32'hB0B0B0B0);
    step(); core(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    check("raw_hold", 32'(hold_flag_o), 32'd1);
    check("raw_ack",  32'(core_ack_o),  32'd0);
    check("raw_we",   32'(bus_we_o),    32'd1);
    expect_op(1'b0, 32'h20, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(); bus_gnt_i = 1'b1;
      @(negedge clk);
      if (bus_req_o && !bus_we_o && bus_gnt_i) found = 1'b1;
    end
    check("raw_read_seen", 32'(found), 32'd1);
    step(); bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFE0001;
    @(negedge clk);
    check("raw_wait_ack",  32'(core_ack_o),  32'd0);
    check("raw_wait_hold", 32'(hold_flag_o), 32'd1);
    step(); bus_rvalid_i = 1'b0;
    @(negedge clk);
    check("raw_done_ack",   32'(core_ack_o),  32'd1);
    check("raw_done_rdata", core_rdata_o,     32'hCAFE0001);
    check("raw_done_hold",  32'(hold_flag_o), 32'd0);
    step(); core(1'b0, 1'b0, 32'h0, 32'h0);

    // Load from an empty FIFO with a slow slave.
    step(); core(1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    check("slow_idle_hold", 32'(hold_flag_o), 32'd1);
    check("slow_idle_req",  32'(bus_req_o),   32'd0);
    expect_op(1'b0, 32'h40, 32'h0);
    step(); bus_gnt_i = 1'b1;
    @(negedge clk);
    check("slow_rreq_req", 32'(bus_req_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(); bus_gnt_i = 1'b0;
      @(negedge clk);
      check("slow_wait_hold", 32'(hold_flag_o), 32'd1);
      check("slow_wait_ack",  32'(core_ack_o),  32'd0);
    end
    step(); bus_rvalid_i = 1'b1; bus_rdata_i = 32'h12345678;
    @(negedge clk);
    check("slow_rv_ack", 32'(core_ack_o), 32'd0);
    step(); bus_rvalid_i = 1'b0;
    @(negedge clk);
    check("slow_ack",   32'(core_ack_o),  32'd1);
    check("slow_rdata", core_rdata_o,     32'h12345678);
    check("slow_hold",  32'(hold_flag_o), 32'd0);
    step(); core(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("slow_ack_once", 32'(core_ack_o), 32'd0);

    // Grant and read data in the same RREQ cycle.
    step(); core(1'b1, 1'b0, 32'h44, 32'h0);
    expect_op(1'b0, 32'h44, 32'h0);
    step(); bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hA5A5A5A5;
    step(); bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    @(negedge clk);
    check("fast_ack",   32'(core_ack_o), 32'd1);
    check("fast_rdata", core_rdata_o,    32'hA5A5A5A5);
    step(); core(1'b0, 1'b0, 32'h0, 32'h0); bus_rvalid_i = 1'b1; bus_rdata_i = 32'h00000BAD;
    @(negedge clk);
    check("stray_rv_ack", 32'(core_ack_o), 32'd0);
    step(); bus_rvalid_i = 1'b0;
    @(negedge clk);
    check("stray_rv_rdata", core_rdata_o, 32'hA5A5A5A5);

    // Reset with a buffered write and a load in DRAIN: the write is discarded.
    step(); core(1'b1, 1'b1, 32'h50, 32'h5555);
    step(); core(1'b1, 1'b0, 32'h60, 32'h0);
    step(); core(1'b0, 1'b0, 32'h0, 32'h0); rst = 1'b1;
    @(negedge clk);
    check("rst_drain_hold", 32'(hold_flag_o), 32'd1);
    step(); rst = 1'b0; sb.delete();
    @(negedge clk);
    check("rst2_req",   32'(bus_req_o),   32'd0);
    check("rst2_hold",  32'(hold_flag_o), 32'd0);
    check("rst2_rdata", core_rdata_o,     32'h0);

    // Reset in RWAIT, then a late response must be ignored.
    step(); core(1'b1, 1'b0, 32'h70, 32'h0);
    expect_op(1'b0, 32'h70, 32'h0);
    step(); bus_gnt_i = 1'b1;
    step(); bus_gnt_i = 1'b0; core(1'b0, 1'b0, 32'h0, 32'h0); rst = 1'b1;
    @(negedge clk);
    check("rwait_hold", 32'(hold_flag_o), 32'd1);
    step(); rst = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000BEEF;
    @(negedge clk);
    check("late_rv_ack",   32'(core_ack_o),  32'd0);
    check("late_rv_hold",  32'(hold_flag_o), 32'd0);
    check("late_rv_req",   32'(bus_req_o),   32'd0);
    step(); bus_rvalid_i = 1'b0;
    @(negedge clk);
    check("late_rv_ack2",  32'(core_ack_o),  32'd0);
    check("late_rv_rdata", core_rdata_o,     32'h0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
